// File: rtl/btn_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_arb_pkg : shared state encoding and width helpers for the button arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package btn_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // cmd_id needs at least one bit even for degenerate counts
  function automatic int idw_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first set req at or after ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_pick
  import btn_arb_pkg::*;
#(
  parameter  int NUM_BTN = 4,
  localparam int IDW     = idw_of(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  localparam int IDX_W = IDW + 1;

  logic [IDX_W-1:0] idx;

  // Scan from the far end so the candidate closest to ptr is assigned last.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= IDX_W'(NUM_BTN)) idx = idx - IDX_W'(NUM_BTN);
      if (req[idx[IDW-1:0]]) begin
        gnt_id = idx[IDW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_event_arbiter : sticky per-button pending flags serialised round-robin
//                     onto a valid/ready command stream with an idle gap
// Revision          : 1.0
// ---------------------------------------------------------------------------
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter  int NUM_BTN    = 4,
  parameter  int GAP_CYCLES = 4,
  localparam int IDW        = idw_of(NUM_BTN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_edge,
  output logic               cmd_valid,
  output logic [IDW-1:0]     cmd_id,
  input  logic               cmd_ready,
  output logic [NUM_BTN-1:0] pending,
  output logic               overflow
);

  state_t                 state_q, state_d;
  logic [NUM_BTN-1:0]     pending_q, pending_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [IDW-1:0]         cmd_id_q, cmd_id_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   overflow_q, overflow_d;

  logic                   handshake;
  logic [NUM_BTN-1:0]     clr;
  logic [IDW-1:0]         pick_id;
  logic                   pick_any;

  rr_pick #(
    .NUM_BTN (NUM_BTN)
  ) u_pick (
    .req    (pending_q),
    .ptr    (ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign handshake = cmd_valid_q && cmd_ready;

  // A fresh edge on the bit being cleared re-arms it rather than overflowing.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      clr[i] = handshake && (cmd_id_q == IDW'(i));
    end
    pending_d  = (pending_q & ~clr) | btn_edge;
    overflow_d = |(btn_edge & pending_q & ~clr);
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_id_d    = cmd_id_q;
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          cmd_id_d    = pick_id;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          cmd_valid_d = 1'b0;
          ptr_d       = (cmd_id_q == IDW'(NUM_BTN - 1)) ? '0 : cmd_id_q + IDW'(1);
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_CNT_W'(GAP_CYCLES);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_CNT_W'(1);
        if (gap_q <= GAP_CNT_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      ptr_q       <= '0;
      gap_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_event_arbiter : directed self-checking bench for btn_event_arbiter
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_btn_event_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] btn_edge;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;
  logic [3:0] pending;
  logic       overflow;

  int n_checks;
  int n_pass;
  int cap_n;
  int cap_w  [8];
  int cap_id [8];

  btn_event_arbiter #(
    .NUM_BTN    (4),
    .GAP_CYCLES (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_edge  (btn_edge),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_ready (cmd_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Steps n cycles, logging the cycle index and id of every offered command.
  task automatic capture(input int n);
    cap_n = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (cmd_valid === 1'b1 && cap_n < 8) begin
        cap_w[cap_n]  = k;
        cap_id[cap_n] = int'(cmd_id);
        cap_n++;
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    btn_edge  = 4'b0000;
    cmd_ready = 1'b0;
    step();
    step();
    check("rst_valid",    32'(cmd_valid), 32'd0);
    check("rst_id",       32'(cmd_id),    32'd0);
    check("rst_pending",  32'(pending),   32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    reset = 1'b0;

    // quiet after reset release
    for (int c = 0; c < 20; c++) begin
      step();
      check("quiet_valid",    32'(cmd_valid), 32'd0);
      check("quiet_pending",  32'(pending),   32'd0);
      check("quiet_overflow", 32'(overflow),  32'd0);
    end

    // single edge latency
    cmd_ready = 1'b1;
    btn_edge  = 4'b0100;
    step();
    btn_edge  = 4'b0000;
    check("lat_pending1", 32'(pending),   32'h4);
    check("lat_valid0",   32'(cmd_valid), 32'd0);
    step();
    check("lat_valid1",   32'(cmd_valid), 32'd1);
    check("lat_id",       32'(cmd_id),    32'd2);
    check("lat_pending2", 32'(pending),   32'h4);
    step();
    check("lat_accepted", 32'(cmd_valid), 32'd0);
    check("lat_cleared",  32'(pending),   32'h0);

    reset = 1'b1;
    step();
    reset = 1'b0;

    // three simultaneous requests from ptr=0
    btn_edge = 4'b1011;
    step();
    btn_edge = 4'b0000;
    check("rr3_pending", 32'(pending), 32'hb);
    capture(20);
    check("rr3_count", 32'(cap_n),     32'd3);
    check("rr3_id0",   32'(cap_id[0]), 32'd0);
    check("rr3_id1",   32'(cap_id[1]), 32'd1);
    check("rr3_id2",   32'(cap_id[2]), 32'd3);
    check("rr3_w0",    32'(cap_w[0]),  32'd1);
    check("rr3_gap1",  32'(cap_w[1] - cap_w[0]), 32'd6);
    check("rr3_gap2",  32'(cap_w[2] - cap_w[1]), 32'd6);
    check("rr3_empty", 32'(pending), 32'h0);

    // ptr back at 0 after granting id 3
    btn_edge = 4'b1001;
    step();
    btn_edge = 4'b0000;
    capture(16);
    check("rr2_count", 32'(cap_n),     32'd2);
    check("rr2_id0",   32'(cap_id[0]), 32'd0);
    check("rr2_id1",   32'(cap_id[1]), 32'd3);
    check("rr2_w0",    32'(cap_w[0]),  32'd1);
    check("rr2_w1",    32'(cap_w[1]),  32'd7);

    // back-pressure with a repeated edge on the in-flight id
    cmd_ready = 1'b0;
    btn_edge  = 4'b0010;
    step();
    btn_edge  = 4'b0000;
    step();
    check("bp_valid", 32'(cmd_valid), 32'd1);
    check("bp_id",    32'(cmd_id),    32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_valid", 32'(cmd_valid), 32'd1);
      check("bp_hold_id",    32'(cmd_id),    32'd1);
      check("bp_no_ovf",     32'(overflow),  32'd0);
    end
    btn_edge = 4'b0010;
    step();
    btn_edge = 4'b0000;
    check("bp_ovf_pulse", 32'(overflow), 32'd1);
    check("bp_ovf_pend",  32'(pending),  32'h2);
    step();
    check("bp_ovf_end",   32'(overflow), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold2_valid", 32'(cmd_valid), 32'd1);
      check("bp_hold2_id",    32'(cmd_id),    32'd1);
      check("bp_hold2_pend",  32'(pending),   32'h2);
    end
    cmd_ready = 1'b1;
    step();
    check("bp_accept_valid", 32'(cmd_valid), 32'd0);
    check("bp_accept_pend",  32'(pending),   32'h0);
    capture(12);
    check("bp_single_grant", 32'(cap_n), 32'd0);

    // edge on id 2 in its own handshake cycle re-arms it
    btn_edge = 4'b0100;
    step();
    btn_edge = 4'b0000;
    step();
    check("rearm_valid", 32'(cmd_valid), 32'd1);
    check("rearm_id",    32'(cmd_id),    32'd2);
    btn_edge = 4'b0100;
    step();
    btn_edge = 4'b0000;
    check("rearm_no_ovf",  32'(overflow),  32'd0);
    check("rearm_pending", 32'(pending),   32'h4);
    check("rearm_dropped", 32'(cmd_valid), 32'd0);
    capture(12);
    check("rearm_count", 32'(cap_n),     32'd1);
    check("rearm_id2",   32'(cap_id[0]), 32'd2);
    check("rearm_w",     32'(cap_w[0]),  32'd5);

    // reset while a command is in flight
    cmd_ready = 1'b0;
    btn_edge  = 4'b0110;
    step();
    btn_edge  = 4'b0000;
    step();
    check("mid_valid",   32'(cmd_valid), 32'd1);
    check("mid_id",      32'(cmd_id),    32'd1);
    check("mid_pending", 32'(pending),   32'h6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid",   32'(cmd_valid), 32'd0);
    check("mid_rst_pending", 32'(pending),   32'h0);
    check("mid_rst_id",      32'(cmd_id),    32'd0);
    cmd_ready = 1'b1;
    btn_edge  = 4'b0110;
    step();
    btn_edge  = 4'b0000;
    step();
    check("post_rst_valid", 32'(cmd_valid), 32'd1);
    check("post_rst_id",    32'(cmd_id),    32'd1);
    capture(10);
    check("post_rst_count", 32'(cap_n),     32'd1);
    check("post_rst_id2",   32'(cap_id[0]), 32'd2);
    check("post_rst_w",     32'(cap_w[0]),  32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
